// File: rtl/uart_rx_frontend.sv
// UART 8N1 receive front-end: 2-flop sync, mid-bit 3-sample majority, valid/ready byte output.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int IDLE_BITS    = 10
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  input  logic       rx_ready,
  input  logic       ovr_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy,
  output logic       idle
);

  localparam int H        = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int IDLE_LIM = IDLE_BITS * CLKS_PER_BIT;
  localparam int IW       = $clog2(IDLE_LIM + 1);

  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_S0   = CW'(H - 1);
  localparam logic [CW-1:0] C_S1   = CW'(H);
  localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
  localparam logic [IW-1:0] I_LIM  = IW'(IDLE_LIM);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_BRK   = 3'd5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [IW-1:0] sat_inc(input logic [IW-1:0] v);
    return (v >= I_LIM) ? v : v + IW'(1);
  endfunction

  logic          sync_p0, sync_p1, rs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    bidx;
  logic          samp_a, samp_b;
  logic [7:0]    shreg;
  logic [IW-1:0] icnt;
  logic          maj, decide, deliver, frame_bad, xfer;

  assign rs        = sync_p1;
  assign maj       = maj3(samp_a, samp_b, rs);
  assign decide    = (state != ST_IDLE) && (state != ST_BRK) && (cnt == C_DEC);
  assign deliver   = decide && (state == ST_STOP) && maj;
  assign frame_bad = decide && (state == ST_STOP) && !maj;
  assign xfer      = rx_valid && rx_ready;
  assign busy      = (state != ST_IDLE);
  assign idle      = (icnt >= I_LIM);

  // Input synchroniser (rx is asynchronous)
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rx;
      sync_p1 <= sync_p0;
    end
  end

  // Frame FSM with bit-time counter
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      bidx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt  <= '0;
          bidx <= '0;
          if (!rs) state <= ST_START;
        end
        ST_BRK: begin
          cnt  <= '0;
          bidx <= '0;
          if (rs) state <= ST_IDLE;
        end
        default: begin
          if (cnt == C_LAST) begin
            cnt  <= '0;
            bidx <= bidx + 4'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
          if (decide) begin
            case (state)
              ST_START: state <= maj ? ST_IDLE : ST_DATA;
              ST_DATA: begin
                if (bidx == 4'd8) begin
`ifdef UART_RX_PARITY_EN
                  state <= ST_PAR;
`else
                  state <= ST_STOP;
`endif
                end
              end
              ST_PAR:  state <= ST_STOP;
              ST_STOP: state <= maj ? ST_IDLE : ST_BRK;
              default: state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // Sample capture and data shift register
`ifdef UART_RX_PARITY_EN
  logic par_bit;
`endif
  always_ff @(posedge clk) begin
    if (cnt == C_S0) samp_a <= rs;
    if (cnt == C_S1) samp_b <= rs;
    if (decide && state == ST_DATA) shreg <= {maj, shreg[7:1]};
`ifdef UART_RX_PARITY_EN
    if (decide && state == ST_PAR) par_bit <= maj;
`endif
  end

  // Output holding register and handshake
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      if (deliver && (!rx_valid || xfer)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (xfer) begin
        rx_valid <= 1'b0;
      end
      // A drop in the same cycle as ovr_clr keeps the flag set
      if (deliver && rx_valid && !xfer) overrun <= 1'b1;
      else if (ovr_clr)                 overrun <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!nrst) parity_err <= 1'b0;
    else       parity_err <= deliver && (par_bit != ^shreg);
  end
`else
  assign parity_err = 1'b0;
`endif

  // Line-idle counter, saturating
  always_ff @(posedge clk) begin
    if (!nrst)                        icnt <= '0;
    else if (state == ST_IDLE && rs) icnt <= sat_inc(icnt);
    else                             icnt <= '0;
  end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
UART receive front-end: 8N1 serial on rx, 12 MHz clk, 9600 baud default. Sits directly upstream of the rx/tx word buffer.
- Synchronises rx, detects the start bit, and samples each bit at mid-bit with 3-sample majority.
- Delivers bytes over a valid/ready interface.
- Flags framing errors and overruns.
- Reports line-idle so the downstream buffer can flush partial words.

Parameters:
CLKS_PER_BIT, 1250, clk cycles per bit (12 MHz / 9600); must be >= 8.
IDLE_BITS, 10, bit times rx must stay high (FSM in IDLE) before idle asserts.

Ports:
clk  in  1  system clock.
nrst  in  1  reset, synchronous, active-low.
rx  in  1  asynchronous serial input, idle high.
rx_ready  in  1  downstream accepts rx_data this cycle.
ovr_clr  in  1  clears overrun.
rx_data  out  8  received byte, LSB = first data bit.
rx_valid  out  1  rx_data holds an unconsumed byte.
frame_err  out  1  one-cycle pulse: stop bit sampled 0.
parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 unless macro is defined).
overrun  out  1  sticky: byte lost because holding register was full.
busy  out  1  FSM not in IDLE.
idle  out  1  line idle for IDLE_BITS bit times.

Behaviour:
Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, idle=0. Sync flops=1, FSM=IDLE, all counters 0.
- Reset mid-frame aborts the frame; no output is produced.

Input sync: 2 flops, then rs = synchronised rx.

Counters:
- cnt counts 0..CLKS_PER_BIT-1, wraps; bit index bidx increments on each wrap.
- cnt=0 is the first cycle after leaving IDLE. H = CLKS_PER_BIT/2 (625).
- Samples taken at cnt = H-1, H, H+1; majority decided at cnt=H+1.

FSM:
- IDLE: rs==0 -> START (cnt=0, bidx=0).
- START: at decision, majority 0 -> DATA; majority 1 -> IDLE (glitch, no flags).
- DATA: bidx 1..8. Decision shifts bit into shift register, LSB first. After bidx 8 -> STOP.
- STOP (bidx 9): decision 1 -> deliver byte, go to IDLE. Decision 0 -> frame_err pulse next cycle, byte discarded, go to BRK.
  - Returning to IDLE at the mid-stop decision lets the next start edge be caught with no dead time.
- BRK: wait for rs==1, then IDLE.

Latency: rx_valid rises at cycle 9*CLKS_PER_BIT+H+2 after cnt=0 (11877 at defaults).

Output handshake:
- Transfer occurs when rx_valid && rx_ready. rx_valid stays high and rx_data stays stable until transfer.
- New byte, rx_valid=0: load rx_data, set rx_valid.
- New byte, transfer in the same cycle: load new byte, rx_valid stays 1, no overrun.
- New byte, rx_valid=1 and no transfer: old byte kept, new byte dropped, overrun=1.
- overrun clears on ovr_clr. If ovr_clr and a new overrun occur in the same cycle, the set wins.

Idle:
- Saturating counter increments while FSM==IDLE and rs==1; it is zeroed otherwise.
- idle=1 when counter >= IDLE_BITS*CLKS_PER_BIT. idle drops in the cycle the FSM leaves IDLE.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: an even-parity bit follows the 8 data bits (bidx 9); stop moves to bidx 10. Latency becomes 10*CLKS_PER_BIT+H+2.
  - Mismatch: the byte is still delivered, parity_err pulses in the same cycle the byte is loaded.
  - Framing error takes precedence: byte discarded, only frame_err pulses.
- Undefined: 8N1 frames, parity_err tied 0.

Test Plan:
- Reset release, rx=1 held -> all outputs 0. idle rises exactly 12500 cycles after the FSM is first seen in IDLE with rs=1.
- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), rx_ready=1 -> rx_valid one cycle at 11877 after cnt=0, rx_data=0xA5, no flags. Repeat with 200 random bytes, including back-to-back frames with zero idle gap.
- 300-cycle low glitch on rx -> no rx_valid, no frame_err, busy high only until cnt=626, then FSM back to IDLE.
- Frame 0x3C with stop bit 0 and rx held low 3 bit times -> frame_err 1-cycle pulse, no rx_valid, busy stays 1 until rx returns high.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun=1. Raise rx_ready -> 0x11 consumed. Pulse ovr_clr -> overrun=0.
- UART_RX_PARITY_EN: frame 0x07 with parity 0 -> rx_data=0x07, parity_err pulse. Same frame with parity 1 -> no pulse.
